// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg : shared types and width codes for the load/store unit       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; 0 marks an unsupported width code.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      F3_W:        size_of = 3'd4;
      default:     size_of = 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_lane_merge : store byte-lane merge and load byte extract/extend  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic        word_idx,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [31:0] w0,
  input  logic [23:0] w1,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [7:0]  w_bmask;
  logic [63:0] w_sdata;
  logic [3:0]  w_lmask;
  logic [31:0] w_ldata;
  logic [31:0] w_raw;

  // Store bytes laid out across a two-word window starting at the offset.
  assign w_bmask = ((8'd1 << size) - 8'd1) << offset;
  assign w_sdata = {32'd0, wdata} << {offset, 3'b000};
  assign w_lmask = word_idx ? w_bmask[7:4] : w_bmask[3:0];
  assign w_ldata = word_idx ? w_sdata[63:32] : w_sdata[31:0];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign merged[8*l +: 8] = w_lmask[l] ? w_ldata[8*l +: 8] : old_word[8*l +: 8];
  end

  // At most three bytes of the second word are ever needed by a load.
  always_comb begin
    case (offset)
      2'd0:    w_raw = w0;
      2'd1:    w_raw = {w1[7:0],  w0[31:8]};
      2'd2:    w_raw = {w1[15:0], w0[31:16]};
      default: w_raw = {w1[23:0], w0[31:24]};
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    rdata = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_H:    rdata = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_BU:   rdata = {24'd0, w_raw[7:0]};
      F3_HU:   rdata = {16'd0, w_raw[15:0]};
      default: rdata = w_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : byte-addressed load/store initiator, split spans   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_w0;

  logic [2:0]  w_req_size;
  logic        w_req_span;
  logic        w_req_illegal;
  logic [2:0]  w_size;
  logic        w_span;
  logic [31:0] w_word0;
  logic [31:0] w_ld_w0;
  logic [31:0] w_merged;
  logic [31:0] w_rdata;

  assign w_req_size    = size_of(req_funct3);
  assign w_req_span    = ({1'b0, req_addr[1:0]} + w_req_size) > 3'd4;
  assign w_req_illegal = (w_req_size == 3'd0) | (req_we & req_funct3[2]) |
                         (w_req_span & !MISALIGNED_EN);

  assign w_size  = size_of(r_funct3);
  assign w_span  = ({1'b0, r_addr[1:0]} + w_size) > 3'd4;
  assign w_word0 = {r_addr[31:2], 2'b00};
  // In ACC0 the first word is still on the bus; in ACC1 it comes from r_w0.
  assign w_ld_w0 = (r_state == ACC1) ? r_w0 : mem_rdata;

  lsu_lane_merge u_lane_merge (
    .offset   (r_addr[1:0]),
    .size     (w_size),
    .word_idx (r_state == ACC1),
    .funct3   (r_funct3),
    .old_word (mem_rdata),
    .wdata    (r_wdata),
    .w0       (w_ld_w0),
    .w1       (mem_rdata[23:0]),
    .merged   (w_merged),
    .rdata    (w_rdata)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign mem_wdata  = w_merged;

  always_comb begin
    mem_addr = 32'd0;
    mem_we   = 1'b0;
    case (r_state)
      ACC0: begin
        mem_addr = w_word0;
        mem_we   = r_we;
      end
      ACC1: begin
        mem_addr = w_word0 + 32'd4;
        mem_we   = r_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_w0       <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_req_illegal) begin
              r_state    <= RESP;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              r_state <= ACC0;
            end
          end
        end
        ACC0: begin
          r_w0 <= mem_rdata;
          if (w_span) begin
            r_state <= ACC1;
          end else begin
            r_state    <= RESP;
            resp_err   <= 1'b0;
            resp_rdata <= r_we ? 32'd0 : w_rdata;
          end
        end
        ACC1: begin
          r_state    <= RESP;
          resp_err   <= 1'b0;
          resp_rdata <= r_we ? 32'd0 : w_rdata;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_unit : scoreboard bench with a word memory model       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_load_store_unit;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_wdata;

  logic        req2_valid = 1'b0, req2_we = 1'b0;
  logic [2:0]  req2_funct3 = 3'd0;
  logic [31:0] req2_addr = 32'd0, req2_wdata = 32'd0;
  logic        req2_ready, resp2_valid, resp2_err, mem2_we;
  logic [31:0] resp2_rdata, mem2_addr, mem2_wdata;
  logic [31:0] mem2_rdata = 32'h12345678;

  logic [31:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_data = 32'd0;

  logic [31:0] addr_log [$];
  int          we_cnt = 0, align_bad = 0, d2_act = 0;
  exp_t        sb [$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MISALIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  load_store_unit #(.MISALIGNED_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req2_valid), .req_ready(req2_ready),
    .req_we(req2_we), .req_funct3(req2_funct3), .req_addr(req2_addr), .req_wdata(req2_wdata),
    .resp_valid(resp2_valid), .resp_rdata(resp2_rdata), .resp_err(resp2_err),
    .mem_addr(mem2_addr), .mem_rdata(mem2_rdata), .mem_we(mem2_we), .mem_wdata(mem2_wdata)
  );

  // 256-word aliased memory: 0x100->64, 0x104->65, 0x0->0, 0xFFFFFFFC->255.
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  always @(negedge clk) begin
    if (!reset && !req_ready && !resp_valid) addr_log.push_back(mem_addr);
    if (mem_we) we_cnt++;
    if (mem_addr[1:0] != 2'b00) align_bad++;
    if (mem2_we || mem2_addr != 32'd0) d2_act++;
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drive(input bit sel, input req_t r, output exp_t o);
    @(negedge clk);
    if (sel) begin
      req2_valid = 1'b1; req2_we = r.we; req2_funct3 = r.f3; req2_addr = r.addr; req2_wdata = r.wdata;
    end else begin
      req_valid = 1'b1; req_we = r.we; req_funct3 = r.f3; req_addr = r.addr; req_wdata = r.wdata;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req2_valid = 1'b0;
    o = '{32'hxxxxxxxx, 1'bx, 4'd0};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((sel ? resp2_valid : resp_valid) === 1'b1) begin
        o = '{(sel ? resp2_rdata : resp_rdata), (sel ? resp2_err : resp_err), 4'(c)};
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got %h/%b want 0/0", resp_rdata, resp_err); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem got we=%b addr=%h want 0/0", mem_we, mem_addr); end
  endtask

  task automatic test_word;
    req_t rq [2]; exp_t ex [2]; exp_t o, x;
    int base;
    rq[0] = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF}; ex[0] = '{32'h0, 1'b0, 4'd2};
    rq[1] = '{1'b0, 3'b010, 32'h100, 32'h0};        ex[1] = '{32'hDEADBEEF, 1'b0, 4'd2};
    base = addr_log.size();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(ex[i]);
      drive(1'b0, rq[i], o);
      x = sb.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL word[%0d] got %h/%b/lat%0d want %h/%b/lat%0d", i, o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
    end
    checks++; if (mem[64] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_mem got %h want deadbeef", mem[64]); end
    checks++;
    if (addr_log.size() != base + 2 || addr_log[base] !== 32'h100 || addr_log[base+1] !== 32'h100) begin
      errors++; $display("FAIL word_addr got %0d accesses want 2 at 0x100", addr_log.size() - base);
    end
  endtask

  task automatic test_subword;
    req_t rq [7]; exp_t ex [7]; exp_t o, x;
    poke(8'd64, 32'h11223344);
    rq[0] = '{1'b1, 3'b000, 32'h101, 32'hFFFFFF80}; ex[0] = '{32'h0, 1'b0, 4'd2};
    rq[1] = '{1'b0, 3'b000, 32'h101, 32'h0};        ex[1] = '{32'hFFFFFF80, 1'b0, 4'd2};
    rq[2] = '{1'b0, 3'b100, 32'h101, 32'h0};        ex[2] = '{32'h00000080, 1'b0, 4'd2};
    rq[3] = '{1'b1, 3'b001, 32'h102, 32'h1234BEEF}; ex[3] = '{32'h0, 1'b0, 4'd2};
    rq[4] = '{1'b0, 3'b001, 32'h102, 32'h0};        ex[4] = '{32'hFFFFBEEF, 1'b0, 4'd2};
    rq[5] = '{1'b0, 3'b101, 32'h102, 32'h0};        ex[5] = '{32'h0000BEEF, 1'b0, 4'd2};
    rq[6] = '{1'b0, 3'b001, 32'h101, 32'h0};        ex[6] = '{32'hFFFFEF80, 1'b0, 4'd2};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(ex[i]);
      drive(1'b0, rq[i], o);
      x = sb.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL subword[%0d] got %h/%b/lat%0d want %h/%b/lat%0d", i, o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
      if (i == 0) begin
        checks++; if (mem[64] !== 32'h11228044) begin errors++; $display("FAIL sb_mem got %h want 11228044", mem[64]); end
      end
    end
    checks++; if (mem[64] !== 32'hBEEF8044) begin errors++; $display("FAIL sh_mem got %h want beef8044", mem[64]); end
  endtask

  task automatic test_span;
    req_t rq [4]; exp_t ex [4]; exp_t o, x;
    poke(8'd64, 32'h11223344);
    poke(8'd65, 32'h55667788);
    rq[0] = '{1'b1, 3'b010, 32'h103, 32'hAABBCCDD}; ex[0] = '{32'h0, 1'b0, 4'd3};
    rq[1] = '{1'b0, 3'b010, 32'h103, 32'h0};        ex[1] = '{32'hAABBCCDD, 1'b0, 4'd3};
    rq[2] = '{1'b0, 3'b101, 32'h103, 32'h0};        ex[2] = '{32'h0000CCDD, 1'b0, 4'd3};
    rq[3] = '{1'b0, 3'b010, 32'h102, 32'h0};        ex[3] = '{32'hBBCCDD22, 1'b0, 4'd3};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      drive(1'b0, rq[i], o);
      x = sb.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL span[%0d] got %h/%b/lat%0d want %h/%b/lat%0d", i, o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
      if (i == 0) begin
        checks++;
        if (mem[64] !== 32'hDD223344 || mem[65] !== 32'h55AABBCC) begin
          errors++; $display("FAIL span_mem got %h %h want dd223344 55aabbcc", mem[64], mem[65]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    exp_t o, x;
    int base;
    poke(8'd255, 32'h9A000000);
    poke(8'd0, 32'h000000BC);
    base = addr_log.size();
    sb.push_back('{32'hFFFFBC9A, 1'b0, 4'd3});
    drive(1'b0, '{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0}, o);
    x = sb.pop_front();
    checks++;
    if (o !== x) begin errors++; $display("FAIL wrap_lh got %h/%b/lat%0d want %h/%b/lat%0d", o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
    checks++;
    if (addr_log.size() != base + 2 || addr_log[base] !== 32'hFFFFFFFC || addr_log[base+1] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %0d accesses want fffffffc then 00000000", addr_log.size() - base);
    end
  endtask

  task automatic test_error;
    req_t rq [3]; exp_t ex [3]; exp_t o, x;
    int we0, d20;
    rq[0] = '{1'b0, 3'b011, 32'h100, 32'h0};        ex[0] = '{32'h0, 1'b1, 4'd1};
    rq[1] = '{1'b1, 3'b100, 32'h100, 32'h000000FF}; ex[1] = '{32'h0, 1'b1, 4'd1};
    rq[2] = '{1'b0, 3'b111, 32'h100, 32'h0};        ex[2] = '{32'h0, 1'b1, 4'd1};
    we0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      drive(1'b0, rq[i], o);
      x = sb.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL err[%0d] got %h/%b/lat%0d want %h/%b/lat%0d", i, o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
    end
    checks++; if (we_cnt != we0) begin errors++; $display("FAIL err_we got %0d writes want 0", we_cnt - we0); end
    repeat (3) @(negedge clk);
    checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin errors++; $display("FAIL err_hold got %h/%b want 0/1", resp_rdata, resp_err); end
    d20 = d2_act;
    sb.push_back('{32'h0, 1'b1, 4'd1});
    drive(1'b1, '{1'b0, 3'b010, 32'h102, 32'h0}, o);
    x = sb.pop_front();
    checks++;
    if (o !== x) begin errors++; $display("FAIL noalign_span got %h/%b/lat%0d want %h/%b/lat%0d", o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
    checks++; if (d2_act != d20) begin errors++; $display("FAIL noalign_mem got %0d active cycles want 0", d2_act - d20); end
    sb.push_back('{32'h12345678, 1'b0, 4'd2});
    drive(1'b1, '{1'b0, 3'b010, 32'h100, 32'h0}, o);
    x = sb.pop_front();
    checks++;
    if (o !== x) begin errors++; $display("FAIL noalign_lw got %h/%b/lat%0d want %h/%b/lat%0d", o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    poke(8'd64, 32'h11223344);
    poke(8'd65, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h103; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h104) begin errors++; $display("FAIL mid_acc1 got we=%b addr=%h want 1/00000104", mem_we, mem_addr); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got we=%b ready=%b want 0/1", mem_we, req_ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_noresp got %0d pulses want 0", seen); end
    checks++;
    if (mem[64] !== 32'hDD223344 || mem[65] !== 32'h55667788) begin
      errors++; $display("FAIL mid_mem got %h %h want dd223344 55667788", mem[64], mem[65]);
    end
  endtask

  task automatic test_back_to_back;
    exp_t o, x;
    logic [31:0] word;
    logic [7:0]  b;
    word = 32'h8001FF7F;
    sb.push_back('{32'h0, 1'b0, 4'd2});
    drive(1'b0, '{1'b1, 3'b010, 32'h100, word}, o);
    x = sb.pop_front();
    checks++;
    if (o !== x) begin errors++; $display("FAIL b2b_sw got %h/%b/lat%0d want %h/%b/lat%0d", o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
    for (int i = 0; i < 4; i++) begin
      b = word[8*i +: 8];
      sb.push_back('{{{24{b[7]}}, b}, 1'b0, 4'd2});
      drive(1'b0, '{1'b0, 3'b000, 32'h100 + i, 32'h0}, o);
      x = sb.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL b2b_lb[%0d] got %h/%b/lat%0d want %h/%b/lat%0d", i, o.rdata, o.err, o.lat, x.rdata, x.err, x.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_span();
    test_wrap();
    test_error();
    test_reset_mid();
    test_back_to_back();
    checks++; if (align_bad != 0) begin errors++; $display("FAIL mem_align got %0d unaligned cycles want 0", align_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
